spi_program_loader: RTL and testbench

Master-side driver for the processor's serial load/run link. Accepts instruction/data frames and run commands from a host over valid/ready handshakes. Serializes each frame onto the link select pair and MOSI line in the exact format the processor's 12-bit receive buffer expects. Runs the loaded program and reports completion or timeout. Sits outside the processor, e.g. in a board-level test harness or companion FPGA, and drives the processor's bidirectional pins 0-2 while reading its done pin 3.

---
 rtl/spi_program_loader_if.sv | 27 ++
 rtl/spi_program_loader.sv | 123 ++++++++++++
 tb/tb_spi_program_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_program_loader_if.sv
// Host handshake and processor link signals of the serial program loader.
// The loader uses the slave modport; the host/harness side uses master.
interface spi_program_loader_if;
  logic       frame_valid;
  logic       frame_is_data;
  logic [3:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_ready;
  logic       run_valid;
  logic       run_ready;
  logic       run_done;
  logic       run_timed_out;
  logic       busy;
  logic [1:0] link_sel;
  logic       link_mosi;
  logic       link_done;

  modport master (
    output frame_valid, frame_is_data, frame_addr, frame_data, run_valid, link_done,
    input  frame_ready, run_ready, run_done, run_timed_out, busy, link_sel, link_mosi
  );

  modport slave (
    input  frame_valid, frame_is_data, frame_addr, frame_data, run_valid, link_done,
    output frame_ready, run_ready, run_done, run_timed_out, busy, link_sel, link_mosi
  );
endinterface

// File: rtl/spi_program_loader.sv
// Serializes 12-bit load frames onto the processor's select/MOSI pins and
// supervises program runs, reporting completion or timeout to the host.
module spi_program_loader #(
  parameter int RUN_TIMEOUT = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_program_loader_if.slave bus
);

  localparam int CNT_W = $clog2(RUN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(2);

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_INSN = 2'b01;
  localparam logic [1:0] SEL_DATA = 2'b10;
  localparam logic [1:0] SEL_RUN  = 2'b11;

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, RUN, FINISH} state_t;

  state_t           state, state_d;
  logic [10:0]      shreg, shreg_d;
  logic [3:0]       bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic             timed_q, timed_d;
  logic [11:0]      word;
  logic             frame_acc, run_acc;

  assign word              = {bus.frame_data, bus.frame_addr};
  assign bus.frame_ready   = (state == IDLE) || (state == GAP);
  assign bus.run_ready     = (state == IDLE) && !bus.frame_valid;
  assign bus.busy          = (state != IDLE);
  assign frame_acc         = bus.frame_valid && bus.frame_ready;
  assign run_acc           = bus.run_valid && bus.run_ready;
  assign bus.link_sel      = sel_q;
  assign bus.link_mosi     = mosi_q;
  assign bus.run_done      = done_q;
  assign bus.run_timed_out = timed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      sel_q   <= SEL_IDLE;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      timed_q <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      cnt     <= cnt_d;
      sel_q   <= sel_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      timed_q <= timed_d;
    end
  end

  // Link outputs are computed one cycle ahead so they leave the registers cleanly.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    cnt_d     = cnt;
    sel_d     = SEL_IDLE;
    mosi_d    = 1'b0;
    done_d    = 1'b0;
    timed_d   = timed_q;
    case (state)
      IDLE, GAP: begin
        if (frame_acc) begin
          state_d   = SHIFT;
          shreg_d   = word[11:1];
          bit_cnt_d = 4'd0;
          sel_d     = bus.frame_is_data ? SEL_DATA : SEL_INSN;
          mosi_d    = word[0];
        end else if (run_acc) begin
          state_d = RUN;
          cnt_d   = '0;
          sel_d   = SEL_RUN;
          timed_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt == 4'd11) begin
          state_d = GAP;
        end else begin
          bit_cnt_d = bit_cnt + 4'd1;
          sel_d     = sel_q;
          mosi_d    = shreg[0];
          shreg_d   = {1'b0, shreg[10:1]};
        end
      end
      RUN: begin
        // The processor's done pin lags enable, so early cycles are not trusted.
        if ((cnt >= CNT_MIN) && bus.link_done) begin
          state_d = FINISH;
          done_d  = 1'b1;
          timed_d = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_d = FINISH;
          done_d  = 1'b1;
          timed_d = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
          sel_d = SEL_RUN;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_program_loader.sv
// Directed bench for spi_program_loader with a small receive-buffer model of
// the processor that commits frames into imem/dmem.
module tb_spi_program_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Expected MOSI sequences, first transmitted bit at index 0.
  localparam logic [0:11] SEQ_I3_A5  = 12'b1100_1010_0101;
  localparam logic [0:11] SEQ_I1_3C  = 12'b1000_0011_1100;
  localparam logic [0:11] SEQ_DF_80  = 12'b1111_0000_0001;

  always #5 clk = ~clk;

  spi_program_loader_if bus();

  spi_program_loader #(.RUN_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [11:0] rx_buf = 12'h000;
  logic [1:0]  rx_prev = 2'b00;
  logic [7:0]  imem [16];
  logic [7:0]  dmem [16];

  // Processor receive buffer: shift in at MSB while selected, commit when select drops.
  always @(posedge clk) begin
    if (bus.link_sel == 2'b01 || bus.link_sel == 2'b10) begin
      rx_buf  <= {bus.link_mosi, rx_buf[11:1]};
      rx_prev <= bus.link_sel;
    end else begin
      if (bus.link_sel == 2'b00 && rx_prev == 2'b01) imem[rx_buf[3:0]] <= rx_buf[11:4];
      if (bus.link_sel == 2'b00 && rx_prev == 2'b10) dmem[rx_buf[3:0]] <= rx_buf[11:4];
      rx_prev <= 2'b00;
    end
  end

  task test_reset;
    bus.frame_valid   = 1'b0;
    bus.frame_is_data = 1'b0;
    bus.frame_addr    = 4'h0;
    bus.frame_data    = 8'h00;
    bus.run_valid     = 1'b0;
    bus.link_done     = 1'b1;
    rst_n             = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.link_sel, bus.link_mosi, bus.run_done, bus.run_timed_out, bus.busy} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {bus.link_sel, bus.link_mosi, bus.run_done, bus.run_timed_out, bus.busy});
    end
    vectors++;
    if ({bus.frame_ready, bus.run_ready} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b expected 11", {bus.frame_ready, bus.run_ready});
    end
    bus.frame_valid = 1'b1;
    #1;
    vectors++;
    if (bus.run_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_run_ready_blocked: got %b expected 0", bus.run_ready);
    end
    bus.frame_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.frame_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got busy/frame_ready %b expected 01", {bus.busy, bus.frame_ready});
    end
  endtask

  task test_instr_frame;
    bus.frame_valid   = 1'b1;
    bus.frame_is_data = 1'b0;
    bus.frame_addr    = 4'h3;
    bus.frame_data    = 8'hA5;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) bus.frame_valid = 1'b0;
      vectors++;
      if ({bus.link_sel, bus.link_mosi} !== {2'b01, SEQ_I3_A5[k]}) begin
        miscompares++;
        $display("[TB] FAIL insn_shift k=%0d: got sel/mosi %b expected %b",
                 k, {bus.link_sel, bus.link_mosi}, {2'b01, SEQ_I3_A5[k]});
      end
    end
    vectors++;
    if ({bus.frame_ready, bus.busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL insn_ready_in_shift: got frame_ready/busy %b expected 01", {bus.frame_ready, bus.busy});
    end
    @(negedge clk);
    vectors++;
    if ({bus.link_sel, bus.link_mosi, bus.frame_ready} !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL insn_gap: got sel/mosi/frame_ready %b expected 0001",
               {bus.link_sel, bus.link_mosi, bus.frame_ready});
    end
    @(negedge clk);
    vectors++;
    if (imem[3] !== 8'hA5 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL insn_commit: got imem[3]=%h busy=%b expected a5 0", imem[3], bus.busy);
    end
  endtask

  task test_back_to_back;
    bus.frame_valid   = 1'b1;
    bus.frame_is_data = 1'b0;
    bus.frame_addr    = 4'h1;
    bus.frame_data    = 8'h3C;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) bus.frame_valid = 1'b0;
      vectors++;
      if ({bus.link_sel, bus.link_mosi} !== {2'b01, SEQ_I1_3C[k]}) begin
        miscompares++;
        $display("[TB] FAIL b2b_first k=%0d: got sel/mosi %b expected %b",
                 k, {bus.link_sel, bus.link_mosi}, {2'b01, SEQ_I1_3C[k]});
      end
    end
    @(negedge clk);
    vectors++;
    if ({bus.link_sel, bus.frame_ready} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap: got sel/frame_ready %b expected 001", {bus.link_sel, bus.frame_ready});
    end
    bus.frame_valid   = 1'b1;
    bus.frame_is_data = 1'b1;
    bus.frame_addr    = 4'hF;
    bus.frame_data    = 8'h80;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) bus.frame_valid = 1'b0;
      vectors++;
      if ({bus.link_sel, bus.link_mosi, bus.frame_ready} !== {2'b10, SEQ_DF_80[k], 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL b2b_second k=%0d: got sel/mosi/frame_ready %b expected %b",
                 k, {bus.link_sel, bus.link_mosi, bus.frame_ready}, {2'b10, SEQ_DF_80[k], 1'b0});
      end
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (imem[1] !== 8'h3C || dmem[15] !== 8'h80) begin
      miscompares++;
      $display("[TB] FAIL b2b_commit: got imem[1]=%h dmem[15]=%h expected 3c 80", imem[1], dmem[15]);
    end
  endtask

  task test_priority;
    bus.frame_valid   = 1'b1;
    bus.frame_is_data = 1'b0;
    bus.frame_addr    = 4'h7;
    bus.frame_data    = 8'h5A;
    bus.run_valid     = 1'b1;
    #1;
    vectors++;
    if ({bus.frame_ready, bus.run_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL prio_ready: got frame_ready/run_ready %b expected 10", {bus.frame_ready, bus.run_ready});
    end
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0) bus.frame_valid = 1'b0;
      vectors++;
      if ({bus.link_sel, bus.run_ready} !== {(k < 12) ? 2'b01 : 2'b00, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL prio_frame_first k=%0d: got sel/run_ready %b expected %b",
                 k, {bus.link_sel, bus.run_ready}, {(k < 12) ? 2'b01 : 2'b00, 1'b0});
      end
    end
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.run_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL prio_idle_run_ready: got busy/run_ready %b expected 01", {bus.busy, bus.run_ready});
    end
    // link_done held high: the shortest possible run of three enable cycles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) bus.run_valid = 1'b0;
      vectors++;
      if (bus.link_sel !== 2'b11) begin
        miscompares++;
        $display("[TB] FAIL prio_run_min c=%0d: got sel %b expected 11", c, bus.link_sel);
      end
    end
    @(negedge clk);
    vectors++;
    if ({bus.link_sel, bus.run_done, bus.run_timed_out} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL prio_finish: got sel/done/timed_out %b expected 0010",
               {bus.link_sel, bus.run_done, bus.run_timed_out});
    end
    @(negedge clk);
    vectors++;
    if (imem[7] !== 8'h5A || {bus.run_done, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL prio_after: got imem[7]=%h done/busy=%b expected 5a 00", imem[7], {bus.run_done, bus.busy});
    end
  endtask

  task test_run;
    bus.run_valid = 1'b1;
    #1;
    vectors++;
    if (bus.run_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL run_ready: got %b expected 1", bus.run_ready);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) bus.run_valid = 1'b0;
      bus.link_done = (c == 0) || (c == 9);
      vectors++;
      if (bus.link_sel !== 2'b11) begin
        miscompares++;
        $display("[TB] FAIL run_enable c=%0d: got sel %b expected 11", c, bus.link_sel);
      end
    end
    @(negedge clk);
    vectors++;
    if ({bus.link_sel, bus.run_done, bus.run_timed_out, bus.busy} !== 5'b00101) begin
      miscompares++;
      $display("[TB] FAIL run_finish: got sel/done/timed_out/busy %b expected 00101",
               {bus.link_sel, bus.run_done, bus.run_timed_out, bus.busy});
    end
    @(negedge clk);
    vectors++;
    if ({bus.run_done, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL run_pulse_width: got done/busy %b expected 00", {bus.run_done, bus.busy});
    end
  endtask

  task test_timeout;
    bus.run_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.run_valid = 1'b0;
        bus.link_done = 1'b0;
      end
      vectors++;
      if (bus.link_sel !== 2'b11) begin
        miscompares++;
        $display("[TB] FAIL timeout_enable c=%0d: got sel %b expected 11", c, bus.link_sel);
      end
    end
    @(negedge clk);
    bus.link_done = 1'b1;
    vectors++;
    if ({bus.link_sel, bus.run_done, bus.run_timed_out} !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL timeout_finish: got sel/done/timed_out %b expected 0011",
               {bus.link_sel, bus.run_done, bus.run_timed_out});
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.run_done, bus.run_timed_out, bus.busy} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL timeout_held: got done/timed_out/busy %b expected 010",
               {bus.run_done, bus.run_timed_out, bus.busy});
    end
    bus.run_valid = 1'b1;
    @(negedge clk);
    bus.run_valid = 1'b0;
    vectors++;
    if ({bus.link_sel, bus.run_timed_out} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL timeout_cleared: got sel/timed_out %b expected 110", {bus.link_sel, bus.run_timed_out});
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.run_done, bus.run_timed_out} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL timeout_rerun_done: got done/timed_out %b expected 10", {bus.run_done, bus.run_timed_out});
    end
    @(negedge clk);
  endtask

  task test_reset_midway;
    logic saw_done;
    bus.frame_valid   = 1'b1;
    bus.frame_is_data = 1'b0;
    bus.frame_addr    = 4'h2;
    bus.frame_data    = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) bus.frame_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.link_sel, bus.link_mosi, bus.busy, bus.frame_ready} !== 5'b00001) begin
      miscompares++;
      $display("[TB] FAIL rst_shift: got sel/mosi/busy/frame_ready %b expected 00001",
               {bus.link_sel, bus.link_mosi, bus.busy, bus.frame_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.run_valid = 1'b1;
    @(negedge clk);
    bus.run_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.link_sel !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL rst_run_started: got sel %b expected 11", bus.link_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.link_sel, bus.run_done, bus.run_timed_out, bus.busy} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL rst_run: got sel/done/timed_out/busy %b expected 00000",
               {bus.link_sel, bus.run_done, bus.run_timed_out, bus.busy});
    end
    saw_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.run_done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0 || {bus.busy, bus.frame_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rst_run_after: got done_seen=%b busy/frame_ready=%b expected 0 01",
               saw_done, {bus.busy, bus.frame_ready});
    end
  endtask

  initial begin
    test_reset;
    test_instr_frame;
    test_back_to_back;
    test_priority;
    test_run;
    test_timeout;
    test_reset_midway;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
